// File: rtl/garage_pkg.sv
// Shared types and defaults for the garage occupancy blocks (gate decoder and occupancy FSM).
package garage_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES  = 1000;

  typedef enum logic [3:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, REJECT, FAULT
  } gate_state_e;

  // States where a car is partway through the beams and the timeout applies.
  function automatic logic is_crossing(gate_state_e s);
    return s inside {IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A};
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus debounce counter for one beam sensor; the level flips
// only after the synchronized input has disagreed with it for DEBOUNCE_CYCLES samples.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = garage_pkg::DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/gate_sensor_decoder.sv
// Entrance beam decoder: turns the A/B beam sequence into car_enter/car_exit pulses and
// drives the barrier. Define GATE_TIMEOUT_EN to add the crossing timeout and FAULT state.
module gate_sensor_decoder
  import garage_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic full,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic car_enter,
  output logic car_exit,
  output logic gate_open,
  output logic fault
);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("gate_sensor_decoder: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  logic da, db;
  logic [1:0] ab;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset(reset), .raw_i(sensor_a), .level_o(da)
  );
  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset(reset), .raw_i(sensor_b), .level_o(db)
  );

  assign ab = {da, db};

  gate_state_e state_q, state_d;
  logic enter_evt_q, enter_evt_d, exit_evt_q, exit_evt_d;
  logic car_enter_q, car_exit_q, gate_open_q;

`ifdef GATE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          fault_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: case (ab)
        2'b10:   state_d = (btn && !full) ? IN_A : REJECT;
        2'b01:   state_d = OUT_B;
        2'b11:   state_d = REJECT;
        default: ;
      endcase
      IN_A:   if (ab == 2'b11) state_d = IN_AB;
              else if (ab == 2'b00) state_d = IDLE;
      IN_AB:  case (ab)
        2'b01:   state_d = IN_B;
        2'b10:   state_d = IN_A;
        2'b00:   state_d = IDLE;
        default: ;
      endcase
      IN_B:   if (ab == 2'b00) state_d = IDLE;
              else if (ab == 2'b11) state_d = IN_AB;
      OUT_B:  if (ab == 2'b11) state_d = OUT_AB;
              else if (ab == 2'b00) state_d = IDLE;
      OUT_AB: case (ab)
        2'b10:   state_d = OUT_A;
        2'b01:   state_d = OUT_B;
        2'b00:   state_d = IDLE;
        default: ;
      endcase
      OUT_A:  if (ab == 2'b00) state_d = IDLE;
              else if (ab == 2'b11) state_d = OUT_AB;
      REJECT: if (ab == 2'b00) state_d = IDLE;
`ifdef GATE_TIMEOUT_EN
      FAULT:  if (ab == 2'b00) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
`ifdef GATE_TIMEOUT_EN
    // A stuck crossing wins over any pattern change seen in the same cycle.
    if (is_crossing(state_q) && tmo_q == TW'(TIMEOUT_CYCLES - 1)) state_d = FAULT;
    tmo_d = (is_crossing(state_q) && state_d == state_q) ? tmo_q + 1'b1 : '0;
`endif
    enter_evt_d = (state_q == IN_B)  && (state_d == IDLE);
    exit_evt_d  = (state_q == OUT_A) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      enter_evt_q <= 1'b0;
      exit_evt_q  <= 1'b0;
      car_enter_q <= 1'b0;
      car_exit_q  <= 1'b0;
      gate_open_q <= 1'b0;
`ifdef GATE_TIMEOUT_EN
      tmo_q       <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      enter_evt_q <= enter_evt_d;
      exit_evt_q  <= exit_evt_d;
      // Pulses land one cycle after the FSM is back in IDLE.
      car_enter_q <= enter_evt_q;
      car_exit_q  <= exit_evt_q;
      gate_open_q <= state_d inside {IN_A, IN_AB, IN_B};
`ifdef GATE_TIMEOUT_EN
      tmo_q       <= tmo_d;
      fault_q     <= (state_d == FAULT);
`endif
    end
  end

  assign car_enter = car_enter_q;
  assign car_exit  = car_exit_q;
  assign gate_open = gate_open_q;
`ifdef GATE_TIMEOUT_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Scoreboard bench for gate_sensor_decoder: stimulus queues expected output edges/pulses
// with their cycle numbers, a monitor pops and compares each one the DUT produces.
module tb_gate_sensor_decoder;

  localparam int DEB = 4;
  localparam int TMO = 50;

  logic clk = 1'b0;
  logic reset, btn, full, sensor_a, sensor_b;
  logic car_enter, car_exit, gate_open, fault;

  gate_sensor_decoder #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .btn(btn), .full(full),
    .sensor_a(sensor_a), .sensor_b(sensor_b),
    .car_enter(car_enter), .car_exit(car_exit), .gate_open(gate_open), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_GRISE, EV_GFALL, EV_ENTER, EV_EXIT, EV_FRISE, EV_FFALL} ev_e;
  typedef struct { ev_e kind; int cyc; } ev_t;
  ev_t exp_q[$];

  int tests = 0;
  int fails = 0;

  // Raw edge to state/gate change: 2 sync + DEB debounce + 1 FSM.
  localparam int LAT = 2 + DEB + 1;

  function automatic void push(ev_e k, int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  function automatic void check_evt(ev_e k, int now);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event got=%s@%0d expected=none", k.name(), now);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != now) begin
        fails++;
        $display("FAIL event got=%s@%0d expected=%s@%0d", k.name(), now, e.kind.name(), e.cyc);
      end
    end
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%b expected=%b", name, act, exp);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge.
  logic go_p = 1'b0, f_p = 1'b0;
  always @(posedge clk) begin
    #2;
    if (gate_open === 1'b1 && !go_p) check_evt(EV_GRISE, cyc);
    if (gate_open === 1'b0 &&  go_p) check_evt(EV_GFALL, cyc);
    if (car_enter === 1'b1)          check_evt(EV_ENTER, cyc);
    if (car_exit  === 1'b1)          check_evt(EV_EXIT,  cyc);
    if (fault === 1'b1 && !f_p)      check_evt(EV_FRISE, cyc);
    if (fault === 1'b0 &&  f_p)      check_evt(EV_FFALL, cyc);
    go_p = (gate_open === 1'b1);
    f_p  = (fault === 1'b1);
  end

  task automatic drv(input logic a, input logic b, output int t);
    @(posedge clk);
    #1;
    sensor_a = a;
    sensor_b = b;
    t = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic exit_seq();
    int t;
    drv(1'b0, 1'b1, t); idle(10);
    drv(1'b1, 1'b1, t); idle(10);
    drv(1'b1, 1'b0, t); idle(10);
    drv(1'b0, 1'b0, t); push(EV_EXIT, t + LAT + 1); idle(15);
  endtask

  task automatic refused_seq();
    int t;
    drv(1'b1, 1'b0, t); idle(10);
    drv(1'b1, 1'b1, t); idle(10);
    drv(1'b0, 1'b1, t); idle(10);
    drv(1'b0, 1'b0, t); idle(15);
  endtask

  initial begin
    int t, r;
    reset = 1'b0; btn = 1'b1; full = 1'b0; sensor_a = 1'b0; sensor_b = 1'b0;
    idle(3);
    #1;
    chk("rst_car_enter", car_enter, 1'b0);
    chk("rst_car_exit",  car_exit,  1'b0);
    chk("rst_gate_open", gate_open, 1'b0);
    chk("rst_fault",     fault,     1'b0);
    reset = 1'b1;
    idle(5);

    // Entry
    drv(1'b1, 1'b0, t); push(EV_GRISE, t + LAT); idle(10);
    drv(1'b1, 1'b1, t); idle(10);
    drv(1'b0, 1'b1, t); idle(10);
    drv(1'b0, 1'b0, t); push(EV_GFALL, t + LAT); push(EV_ENTER, t + LAT + 1); idle(15);

    // Exit, open and then closed+full
    exit_seq();
    btn = 1'b0; full = 1'b1;
    exit_seq();

    // Refused entry: full, then closed
    btn = 1'b1; full = 1'b1;
    refused_seq();
    btn = 1'b0; full = 1'b0;
    refused_seq();
    btn = 1'b1; full = 1'b0;

    // Backing out: A, AB, A, clear
    drv(1'b1, 1'b0, t); push(EV_GRISE, t + LAT); idle(10);
    drv(1'b1, 1'b1, t); idle(10);
    drv(1'b1, 1'b0, t); idle(10);
    drv(1'b0, 1'b0, t); push(EV_GFALL, t + LAT); idle(15);

    // 3-cycle glitch on B while idle
    drv(1'b0, 1'b1, t); idle(2);
    drv(1'b0, 1'b0, t); idle(15);
    chk("glitch_gate_open", gate_open, 1'b0);

    // Timeout: hold A for 100 cycles
    drv(1'b1, 1'b0, t); push(EV_GRISE, t + LAT);
`ifdef GATE_TIMEOUT_EN
    push(EV_GFALL, t + LAT + TMO);
    push(EV_FRISE, t + LAT + TMO);
`endif
    idle(100);
    #1;
`ifdef GATE_TIMEOUT_EN
    chk("tmo_fault_held", fault, 1'b1);
    chk("tmo_gate_held",  gate_open, 1'b0);
`else
    chk("tmo_fault_held", fault, 1'b0);
    chk("tmo_gate_held",  gate_open, 1'b1);
`endif
    drv(1'b0, 1'b0, t);
`ifdef GATE_TIMEOUT_EN
    push(EV_FFALL, t + LAT);
`else
    push(EV_GFALL, t + LAT);
`endif
    idle(15);

    // Reset mid-crossing in IN_AB
    drv(1'b1, 1'b0, t); push(EV_GRISE, t + LAT); idle(10);
    drv(1'b1, 1'b1, t); idle(10);
    @(posedge clk);
    #1;
    reset = 1'b0;
    r = cyc;
    push(EV_GFALL, r + 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midrst_car_enter", car_enter, 1'b0);
    chk("midrst_car_exit",  car_exit,  1'b0);
    chk("midrst_gate_open", gate_open, 1'b0);
    chk("midrst_fault",     fault,     1'b0);
    drv(1'b0, 1'b1, t); idle(10);
    drv(1'b0, 1'b0, t); idle(20);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events got=%0d expected=0 first=%s@%0d",
               exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gate_sensor_decoder.md
# gate_sensor_decoder

Upstream front-end of the garage occupancy system. It watches two beam sensors at the garage entrance and outputs one-cycle entry and exit events. It also drives the entry barrier and refuses entry when the garage is closed or full. Its `car_enter` and `car_exit` pulses feed the occupancy counter FSM, which returns `full`.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples required before a sensor level is accepted (≥1).
- `TIMEOUT_CYCLES`, 1000: maximum cycles a car may stay inside a crossing sequence before it is flagged as a fault (used only with `GATE_TIMEOUT_EN`).
- `clk` in 1: single clock; every flop is rising-edge.
- `reset` in 1: synchronous, active-low reset.
- `btn` in 1: 1 = garage open, 0 = garage closed.
- `full` in 1: 1 = no free places (driven by the occupancy stage).
- `sensor_a` in 1: outer beam, 1 = beam broken. Asynchronous input.
- `sensor_b` in 1: inner beam, 1 = beam broken. Asynchronous input.
- `car_enter` out 1: one-cycle pulse when a complete entry crossing finishes.
- `car_exit` out 1: one-cycle pulse when a complete exit crossing finishes.
- `gate_open` out 1: barrier lift command.
- `fault` out 1: crossing timeout flag.

## Operation
- **Input conditioning.** Each sensor passes through a 2-flop synchronizer and then a debounce counter. The debounced level `da`/`db` changes only after the raw synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- **States:** `IDLE`, `IN_A`, `IN_AB`, `IN_B`, `OUT_B`, `OUT_AB`, `OUT_A`, `REJECT`, `FAULT`.
- **From `IDLE`:**
  - `da & ~db`: if `btn` = 1 and `full` = 0, go to `IN_A`; otherwise go to `REJECT`.
  - `db & ~da`: go to `OUT_B`. Exit is always allowed, regardless of `btn` or `full`.
  - `da & db` in the same cycle: go to `REJECT` (ambiguous).
- **Entry path:** `IN_A` → `IN_AB` on `{da,db}` = 11 → `IN_B` on 01 → `IDLE` on 00, pulsing `car_enter`.
- **Exit path:** `OUT_B` → `OUT_AB` on 11 → `OUT_A` on 10 → `IDLE` on 00, pulsing `car_exit`.
- **Backing out** (reversal to an earlier pattern):
  - In the `IN_*`/`OUT_*` states, the pattern of the previous state moves the FSM back to that state.
  - 00 seen in `IN_A`, `IN_AB`, `OUT_B` or `OUT_AB` returns to `IDLE` with no pulse.
- **`REJECT`:** stays until `{da,db}` = 00, then returns to `IDLE`. It never produces a pulse.
- **`gate_open`:** 1 in `IN_A`, `IN_AB` and `IN_B`; 0 in all other states.
- **Mid-crossing changes of `btn`/`full`:** a change after entering `IN_A` does not abort the crossing. The car already under the barrier completes.

## Timing
- **Reset values:** state = `IDLE`; synchronizers, debounce counters and `da`/`db` = 0; `car_enter`, `car_exit`, `gate_open`, `fault` = 0.
- **Registered outputs:** all outputs are flops decoded from the next state.
- **Pulse timing:** `car_enter` (or `car_exit`) is high exactly one cycle, the cycle after the state register returns to `IDLE` from `IN_B` (or `OUT_A`).
- **Edge latency:** raw sensor edge to state change = 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- **Pulse exclusivity:** `car_enter` and `car_exit` are never high in the same cycle. There are never two pulses closer than `DEBOUNCE_CYCLES` + 1 cycles apart.
- **Glitches:** a sensor pulse shorter than `DEBOUNCE_CYCLES` cycles has no effect.
- **Reset mid-crossing:** takes effect on the next edge. No pulse is emitted. After release the FSM starts in `IDLE` with `da`/`db` = 0, so a still-broken beam is re-qualified through the debouncer.

## Configuration
- **With `GATE_TIMEOUT_EN` defined:**
  - A counter runs while the state is any `IN_*` or `OUT_*` state and clears on every state change.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to `FAULT`: `fault` = 1, `gate_open` = 0, no pulse.
  - `FAULT` exits to `IDLE` when `{da,db}` = 00. `fault` drops in the same cycle the FSM returns to `IDLE`.
- **Without `GATE_TIMEOUT_EN`:** no counter and no `FAULT` state; `fault` is tied to 0.

## Structure
- **Shared package `garage_pkg`:** the state enum typedef and the `DEBOUNCE_CYCLES`/`TIMEOUT_CYCLES` defaults, shared with the occupancy FSM.
- **Sub-module `sensor_debounce`:** one synchronizer plus debounce counter, parameterized by `DEBOUNCE_CYCLES`, instantiated once per sensor.
- **Top of this block:** the FSM and the output flops live in `gate_sensor_decoder` itself.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `TIMEOUT_CYCLES` = 50, with `GATE_TIMEOUT_EN` defined unless stated.
- **Entry:** `btn` = 1, `full` = 0; drive A=1 (10 cy), A=B=1 (10), B=1 (10), both 0 → one `car_enter` pulse 8 cycles after the final clear, `car_exit` stays 0, `gate_open` high from 7 cycles after the A rise until `IDLE`.
- **Exit:** B, AB, A, clear → one `car_exit` pulse. Repeat with `btn` = 0, `full` = 1 → still one `car_exit` pulse.
- **Refused entry:** `full` = 1; run the full entry sequence → no pulse, `gate_open` never rises. Repeat with `btn` = 0 → same result.
- **Backing out:** A, AB, A, clear → no pulse. A 3-cycle glitch on B while `IDLE` → state unchanged.
- **Timeout:** hold A=1 for 100 cycles → `fault` = 1 about 57 cycles after the A edge. Clear A → `fault` = 0, back to `IDLE`. Build without `GATE_TIMEOUT_EN` → `fault` stays 0 and the FSM remains in `IN_A`.
- **Reset mid-crossing:** `reset` = 0 for 1 cycle while in `IN_AB` → all outputs 0 next cycle. Continuing B then clear → no `car_enter` pulse.
